// File: rtl/latex_line_receiver_if.sv
// Byte-stream handshake between a LaTeX character source and latex_line_receiver.
// The source drives in_data/in_valid; the receiver drives in_ready.
interface latex_line_receiver_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/latex_line_receiver.sv
// Captures one 0x00/0x0A-terminated ASCII line into a buffer; reports length, checksum, overflow.
// Optional brace-balance checker (brace_err port) enabled by defining LATEX_BRACE_CHECK_EN.
module latex_line_receiver #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  latex_line_receiver_if.slave  in_if,
  input  logic                  clear,
  input  logic [AW-1:0]         rd_addr,
  output logic [7:0]            rd_data,
  output logic                  line_done,
  output logic [AW:0]           line_len,
  output logic [7:0]            line_sum,
`ifdef LATEX_BRACE_CHECK_EN
  output logic                  overflow,
  output logic                  brace_err
`else
  output logic                  overflow
`endif
);

  if ((DEPTH < 2) || (DEPTH > 64) || ((1 << AW) != DEPTH)) begin : g_param_check
    $error("latex_line_receiver: DEPTH must be a power of 2 in 2..64 and equal 2**AW");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEN  = (AW+1)'(1);

  state_t       state_q;
  logic         ready_q;
  logic         line_done_q;
  logic [AW:0]  line_len_q;
  logic [7:0]   line_sum_q;
  logic         overflow_q;
  logic [7:0]   rd_data_q;
  logic [7:0]   mem_q [DEPTH];

  logic         xfer;
  logic         is_term;
  logic         has_room;
  logic         store;

  always_comb begin
    xfer     = in_if.in_valid && in_if.in_ready;
    is_term  = (in_if.in_data == 8'h00) || (in_if.in_data == 8'h0A);
    has_room = line_len_q < FULL_LEN;
    store    = xfer && !is_term && has_room;
  end

  // ready_q tracks "not DONE and out of reset"; clear gates it combinationally so a
  // byte offered alongside clear is never consumed.
  assign in_if.in_ready = ready_q && !clear;

`ifdef LATEX_BRACE_CHECK_EN
  logic [3:0] depth_q;
  logic       brace_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q     <= '0;
      brace_err_q <= 1'b0;
    end else if (clear) begin
      depth_q     <= '0;
      brace_err_q <= 1'b0;
    end else if (store && (in_if.in_data == 8'h7B)) begin
      if (depth_q == 4'hF) begin
        brace_err_q <= 1'b1;
      end else begin
        depth_q <= depth_q + 4'd1;
      end
    end else if (store && (in_if.in_data == 8'h7D)) begin
      if (depth_q == 4'h0) begin
        brace_err_q <= 1'b1;
      end else begin
        depth_q <= depth_q - 4'd1;
      end
    end else if (xfer && is_term && (depth_q != 4'h0)) begin
      brace_err_q <= 1'b1;
    end
  end

  assign brace_err = brace_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      line_done_q <= 1'b0;
      line_len_q  <= '0;
      line_sum_q  <= '0;
      overflow_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      line_done_q <= 1'b0;
      line_len_q  <= '0;
      line_sum_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, RECV: begin
          ready_q <= 1'b1;
          if (xfer) begin
            if (is_term) begin
              state_q     <= DONE;
              ready_q     <= 1'b0;
              line_done_q <= 1'b1;
            end else begin
              state_q <= RECV;
              if (has_room) begin
                line_len_q <= line_len_q + ONE_LEN;
                line_sum_q <= line_sum_q + in_if.in_data;
              end else begin
                overflow_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          ready_q     <= 1'b0;
          line_done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Buffer contents are don't-care after reset; only line_len_q qualifies reads.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[line_len_q[AW-1:0]] <= in_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr} < line_len_q) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data   = rd_data_q;
  assign line_done = line_done_q;
  assign line_len  = line_len_q;
  assign line_sum  = line_sum_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_latex_line_receiver.sv
// Directed self-checking bench for latex_line_receiver (DEPTH=32); brace checks when LATEX_BRACE_CHECK_EN.
module tb_latex_line_receiver;
  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        line_done;
  logic [5:0]  line_len;
  logic [7:0]  line_sum;
  logic        overflow;
`ifdef LATEX_BRACE_CHECK_EN
  logic        brace_err;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  latex_line_receiver_if bus ();

  latex_line_receiver #(.DEPTH(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (bus.slave),
    .clear     (clear),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .line_done (line_done),
    .line_len  (line_len),
    .line_sum  (line_sum),
`ifdef LATEX_BRACE_CHECK_EN
    .overflow  (overflow),
    .brace_err (brace_err)
`else
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [7:0] line1 [7];

  initial begin
    line1[0] = 8'h65; line1[1] = 8'h5E; line1[2] = 8'h7B; line1[3] = 8'h61;
    line1[4] = 8'h74; line1[5] = 8'h7D; line1[6] = 8'h0A;

    rst_n = 1'b0; clear = 1'b0; rd_addr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_line_sum", line_sum, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", bus.in_ready, 1);

    // "e^{at}" + LF, in_valid held high
    for (int i = 0; i < 7; i++) send(line1[i]);
    chk("l1_line_done", line_done, 1);
    chk("l1_line_len", line_len, 6);
    chk("l1_line_sum", line_sum, 8'h90);
    chk("l1_overflow", overflow, 0);
    chk("l1_in_ready", bus.in_ready, 0);
`ifdef LATEX_BRACE_CHECK_EN
    chk("l1_brace_err", brace_err, 0);
`endif
    rd_addr = 5'd2;
    tick();
    chk("l1_rd2", rd_data, 8'h7B);
    rd_addr = 5'd6;
    tick();
    chk("l1_rd6_past_len", rd_data, 0);

    // DONE holds against a pushy source
    bus.in_valid = 1'b1; bus.in_data = 8'h78;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("done_in_ready", bus.in_ready, 0);
    end
    chk("done_hold_len", line_len, 6);
    chk("done_hold_sum", line_sum, 8'h90);
    chk("done_hold_done", line_done, 1);
    bus.in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clear_gates_ready", bus.in_ready, 0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_line_done", line_done, 0);
    chk("clr_line_len", line_len, 0);
    chk("clr_line_sum", line_sum, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_in_ready", bus.in_ready, 1);

    // NUL as first byte: empty line
    send(8'h00);
    chk("nul_line_done", line_done, 1);
    chk("nul_line_len", line_len, 0);
    chk("nul_line_sum", line_sum, 0);
    rd_addr = 5'd0;
    tick();
    chk("nul_rd0", rd_data, 0);
    do_clear();

    // 40 'a' then LF: 8 dropped
    for (int i = 0; i < 33; i++) send(8'h61);
    chk("ovf_at33_len", line_len, 32);
    chk("ovf_at33_flag", overflow, 1);
    for (int i = 0; i < 7; i++) send(8'h61);
    send(8'h0A);
    chk("ovf_line_len", line_len, 32);
    chk("ovf_line_sum", line_sum, 8'h20);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_line_done", line_done, 1);
    rd_addr = 5'd31;
    tick();
    chk("ovf_rd31", rd_data, 8'h61);
    do_clear();

    // clear mid-line with a byte offered: byte must not be consumed
    send(8'h61); send(8'h62);
    chk("mid_len_before", line_len, 2);
    chk("mid_sum_before", line_sum, 8'hC3);
    bus.in_valid = 1'b1; bus.in_data = 8'h73; clear = 1'b1;
    #1;
    chk("mid_clear_ready", bus.in_ready, 0);
    tick();
    clear = 1'b0; bus.in_valid = 1'b0;
    chk("mid_clear_len", line_len, 0);
    chk("mid_clear_sum", line_sum, 0);
    send(8'h71); send(8'h0A);
    chk("mid_after_len", line_len, 1);
    chk("mid_after_sum", line_sum, 8'h71);
    do_clear();

    // asynchronous reset mid-line, between clock edges
    rd_addr = 5'd0;
    send(8'h7A); send(8'h7A);
    chk("arst_pre_rd", rd_data, 8'h7A);
    chk("arst_pre_len", line_len, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_line_len", line_len, 0);
    chk("arst_line_sum", line_sum, 0);
    chk("arst_line_done", line_done, 0);
    rst_n = 1'b1;
    tick();
    chk("arst_post_ready", bus.in_ready, 1);
    chk("arst_post_len", line_len, 0);

`ifdef LATEX_BRACE_CHECK_EN
    send(8'h7D); send(8'h7B); send(8'h0A);
    chk("br_underflow", brace_err, 1);
    do_clear();
    chk("br_clear", brace_err, 0);
    send(8'h7B); send(8'h7B); send(8'h7D); send(8'h00);
    chk("br_unclosed", brace_err, 1);
    do_clear();
    send(8'h7B); send(8'h7D); send(8'h00);
    chk("br_balanced", brace_err, 0);
    do_clear();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
